vu_frame_ctrl: RTL and testbench

- Frame-synchronous update controller between the audio level producers and the VGA bar renderer of the VU meter.
- Arbitrates level-update requests from the left and right channels with a round-robin arbiter.
- Accumulates each channel's per-frame peak, then commits new bar and peak-hold values only at the start of vertical blanking, so the renderer never sees a level change mid-frame.
- Runs in the pixel clock domain, next to the VGA timing generator that supplies `vblank_start`.

---
 rtl/vu_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_vu_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_frame_ctrl.sv
// vu_frame_ctrl: frame-synchronous level update controller for the VU meter.
// Collects per-channel peaks from the level producers through a round-robin
// arbiter and commits bar / peak-hold values only at the start of vblank.
`timescale 1ns/1ps

module vu_frame_ctrl #(
    parameter int lvl_w       = 6,
    parameter int lvl_max     = 40,
    parameter int hold_frames = 30,
    parameter int hold_w      = 5,
    parameter int decay_step  = 1
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic             vblank_start,
    input  logic             l_valid,
    input  logic [lvl_w-1:0] l_level,
    output logic             l_ready,
    input  logic             r_valid,
    input  logic [lvl_w-1:0] r_level,
    output logic             r_ready,
    output logic [lvl_w-1:0] bar_l,
    output logic [lvl_w-1:0] bar_r,
    output logic [lvl_w-1:0] peak_l,
    output logic [lvl_w-1:0] peak_r,
    output logic             frame_commit,
    output logic             busy
);

    localparam logic [lvl_w-1:0]  LVL_MAX   = lvl_w'(lvl_max);
    localparam logic [lvl_w-1:0]  DSTEP     = lvl_w'(decay_step);
    localparam logic [hold_w-1:0] HOLD_INIT = hold_w'(hold_frames);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT_L = 2'd1,
        S_COMMIT_R = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Round-robin pointer: 1 means R wins the next tie.
    logic             r_prio_r;
    logic             w_idle;
    logic             w_grant_l;
    logic             w_grant_r;

    logic [lvl_w-1:0] r_pend_l;
    logic [lvl_w-1:0] r_pend_r;
    logic             r_pend_v_l;
    logic             r_pend_v_r;
    logic [lvl_w-1:0] w_lvl_l;
    logic [lvl_w-1:0] w_lvl_r;

    logic [hold_w-1:0] r_hold_l;
    logic [hold_w-1:0] r_hold_r;
    logic [lvl_w-1:0]  w_new_bar_l;
    logic [lvl_w-1:0]  w_new_bar_r;
    logic [lvl_w+hold_w-1:0] w_ph_l;
    logic [lvl_w+hold_w-1:0] w_ph_r;

    // Clamp an incoming level to full scale.
    function automatic logic [lvl_w-1:0] f_clamp(input logic [lvl_w-1:0] v);
        return (v > LVL_MAX) ? LVL_MAX : v;
    endfunction

    // Decrement by the decay step, saturating at zero; one extra bit catches the borrow.
    function automatic logic [lvl_w-1:0] f_decay(input logic [lvl_w-1:0] v);
        logic [lvl_w:0] d;
        d = {1'b0, v} - {1'b0, DSTEP};
        return d[lvl_w] ? '0 : d[lvl_w-1:0];
    endfunction

    // Next bar: instant attack on any pending level, otherwise slow decay.
    function automatic logic [lvl_w-1:0] f_new_bar(input logic pv,
                                                   input logic [lvl_w-1:0] pend,
                                                   input logic [lvl_w-1:0] bar);
        return pv ? pend : f_decay(bar);
    endfunction

    // Next {peak, hold}: capture on a new high, hold for a while, then decay
    // but never below the bar it marks.
    function automatic logic [lvl_w+hold_w-1:0] f_peak_hold(input logic [lvl_w-1:0]  nb,
                                                            input logic [lvl_w-1:0]  pk,
                                                            input logic [hold_w-1:0] hd);
        logic [lvl_w-1:0] pd;
        pd = f_decay(pk);
        if (nb >= pk)
            return {nb, HOLD_INIT};
        else if (hd != '0)
            return {pk, hd - hold_w'(1)};
        else
            return {((pd > nb) ? pd : nb), hd};
    endfunction

    // Arbitration and ready generation; only the idle state accepts levels.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_grant_l = l_valid && (!r_valid || !r_prio_r);
        w_grant_r = r_valid && (!l_valid ||  r_prio_r);
        l_ready   = w_idle && !reset && w_grant_l;
        r_ready   = w_idle && !reset && w_grant_r;
        w_lvl_l   = f_clamp(l_level);
        w_lvl_r   = f_clamp(r_level);
    end

    // Commit value computation for both channels.
    always_comb begin
        w_new_bar_l = f_new_bar(r_pend_v_l, r_pend_l, bar_l);
        w_new_bar_r = f_new_bar(r_pend_v_r, r_pend_r, bar_r);
        w_ph_l      = f_peak_hold(w_new_bar_l, peak_l, r_hold_l);
        w_ph_r      = f_peak_hold(w_new_bar_r, peak_r, r_hold_r);
    end

    // FSM state register.
    always_ff @(posedge pixel_clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // FSM next-state: wait for vblank, then one cycle per commit step.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (vblank_start) w_next = S_COMMIT_L;
            S_COMMIT_L: w_next = S_COMMIT_R;
            S_COMMIT_R: w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        frame_commit = (r_state == S_DONE);
        busy         = (r_state != S_IDLE);
    end

    // Per-frame peak staging and round-robin pointer update.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_pend_l   <= '0;
            r_pend_r   <= '0;
            r_pend_v_l <= 1'b0;
            r_pend_v_r <= 1'b0;
            r_prio_r   <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_pend_v_l <= 1'b0;
                r_pend_v_r <= 1'b0;
            end
            if (l_ready) begin
                r_pend_l   <= (r_pend_v_l && (r_pend_l > w_lvl_l)) ? r_pend_l : w_lvl_l;
                r_pend_v_l <= 1'b1;
                r_prio_r   <= 1'b1;
            end
            if (r_ready) begin
                r_pend_r   <= (r_pend_v_r && (r_pend_r > w_lvl_r)) ? r_pend_r : w_lvl_r;
                r_pend_v_r <= 1'b1;
                r_prio_r   <= 1'b0;
            end
        end
    end

    // Displayed bar / peak registers; each channel updates in its own commit cycle.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            bar_l    <= '0;
            bar_r    <= '0;
            peak_l   <= '0;
            peak_r   <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else begin
            if (r_state == S_COMMIT_L) begin
                bar_l              <= w_new_bar_l;
                {peak_l, r_hold_l} <= w_ph_l;
            end
            if (r_state == S_COMMIT_R) begin
                bar_r              <= w_new_bar_r;
                {peak_r, r_hold_r} <= w_ph_r;
            end
        end
    end

endmodule

// File: tb/tb_vu_frame_ctrl.sv
// Directed self-checking bench for vu_frame_ctrl.
`timescale 1ns/1ps

module tb_vu_frame_ctrl;

    logic       pixel_clock = 1'b0;
    logic       reset = 1'b0;
    logic       vblank_start = 1'b0;
    logic       l_valid = 1'b0;
    logic [5:0] l_level = '0;
    logic       l_ready;
    logic       r_valid = 1'b0;
    logic [5:0] r_level = '0;
    logic       r_ready;
    logic [5:0] bar_l, bar_r, peak_l, peak_r;
    logic       frame_commit, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_fc  = 0;

    vu_frame_ctrl dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .vblank_start(vblank_start),
        .l_valid     (l_valid),
        .l_level     (l_level),
        .l_ready     (l_ready),
        .r_valid     (r_valid),
        .r_level     (r_level),
        .r_ready     (r_ready),
        .bar_l       (bar_l),
        .bar_r       (bar_r),
        .peak_l      (peak_l),
        .peak_r      (peak_r),
        .frame_commit(frame_commit),
        .busy        (busy)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Count frame_commit pulses, one sample per cycle.
    always @(negedge pixel_clock) if (frame_commit === 1'b1) n_fc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge pixel_clock);
        reset = 1'b1; l_valid = 1'b0; r_valid = 1'b0; vblank_start = 1'b0;
        repeat (2) @(negedge pixel_clock);
        reset = 1'b0;
    endtask

    task automatic send(input bit ch, input logic [5:0] lvl);
        int t;
        @(negedge pixel_clock);
        if (ch) begin r_valid = 1'b1; r_level = lvl; end
        else    begin l_valid = 1'b1; l_level = lvl; end
        #1;
        t = 0;
        while (((ch ? r_ready : l_ready) !== 1'b1) && t < 20) begin
            @(negedge pixel_clock); #1; t++;
        end
        n_cmp++;
        if (t >= 20) begin
            n_bad++;
            $display("FAIL send_timeout: ch %0d level %0d got ready 0 expected 1 within 20 cycles", ch, lvl);
        end
        @(posedge pixel_clock); #1;
        l_valid = 1'b0; r_valid = 1'b0;
    endtask

    task automatic vblank_pulse();
        @(negedge pixel_clock);
        vblank_start = 1'b1;
        @(posedge pixel_clock); #1;
        vblank_start = 1'b0;
    endtask

    task automatic commit_wait();
        vblank_pulse();
        repeat (3) @(posedge pixel_clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge pixel_clock);
        reset = 1'b1; l_valid = 1'b1; l_level = 6'd0;
        #1;
        n_cmp++; if (l_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready0: got %b expected 0", l_ready); end
        @(negedge pixel_clock);
        n_cmp++; if (l_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready1: got %b expected 0", l_ready); end
        @(negedge pixel_clock);
        n_cmp++; if ({bar_l, bar_r, peak_l, peak_r} !== 24'd0) begin n_bad++;
            $display("FAIL reset_levels: got %h expected 0", {bar_l, bar_r, peak_l, peak_r}); end
        n_cmp++; if ({frame_commit, busy, r_ready} !== 3'b000) begin n_bad++;
            $display("FAIL reset_status: got %b expected 000", {frame_commit, busy, r_ready}); end
        reset = 1'b0;
        #1;
        n_cmp++; if (l_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b expected 1", l_ready); end
        @(posedge pixel_clock); #1;
        l_valid = 1'b0;
    endtask

    task automatic test_single_frame();
        int fc0;
        do_reset();
        send(0, 6'd12); send(0, 6'd25); send(0, 6'd7); send(1, 6'd33);
        fc0 = n_fc;
        vblank_pulse();
        @(negedge pixel_clock);
        n_cmp++; if (busy !== 1'b1 || bar_l !== 6'd0) begin n_bad++;
            $display("FAIL sf_edgeN: got busy %b bar_l %0d expected busy 1 bar_l 0", busy, bar_l); end
        @(negedge pixel_clock);
        n_cmp++; if (bar_l !== 6'd25 || peak_l !== 6'd25 || bar_r !== 6'd0) begin n_bad++;
            $display("FAIL sf_commit_l: got bar_l %0d peak_l %0d bar_r %0d expected 25 25 0", bar_l, peak_l, bar_r); end
        @(negedge pixel_clock);
        n_cmp++; if (bar_r !== 6'd33 || peak_r !== 6'd33) begin n_bad++;
            $display("FAIL sf_commit_r: got bar_r %0d peak_r %0d expected 33 33", bar_r, peak_r); end
        n_cmp++; if (frame_commit !== 1'b1 || busy !== 1'b1) begin n_bad++;
            $display("FAIL sf_done: got commit %b busy %b expected 1 1", frame_commit, busy); end
        @(negedge pixel_clock);
        n_cmp++; if (frame_commit !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL sf_idle: got commit %b busy %b expected 0 0", frame_commit, busy); end
        repeat (3) @(negedge pixel_clock);
        n_cmp++; if (n_fc - fc0 !== 1) begin n_bad++;
            $display("FAIL sf_commit_count: got %0d expected 1", n_fc - fc0); end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge pixel_clock);
        l_valid = 1'b1; r_valid = 1'b1; l_level = 6'd3; r_level = 6'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (l_ready !== (i % 2 == 0) || r_ready !== (i % 2 == 1)) begin n_bad++;
                $display("FAIL rr_grant%0d: got l %b r %b expected l %b r %b", i, l_ready, r_ready, (i % 2 == 0), (i % 2 == 1)); end
            @(negedge pixel_clock);
        end
        // L wins the tie again on the vblank edge, with a new level.
        l_level = 6'd9; vblank_start = 1'b1;
        #1;
        n_cmp++; if (l_ready !== 1'b1) begin n_bad++; $display("FAIL rr_grant4: got %b expected 1", l_ready); end
        @(posedge pixel_clock); #1;
        vblank_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge pixel_clock);
            n_cmp++; if (l_ready !== 1'b0 || r_ready !== 1'b0) begin n_bad++;
                $display("FAIL stall%0d: got l %b r %b expected 0 0", k, l_ready, r_ready); end
        end
        @(negedge pixel_clock);
        n_cmp++; if (r_ready !== 1'b1 || l_ready !== 1'b0) begin n_bad++;
            $display("FAIL resume: got l %b r %b expected 0 1", l_ready, r_ready); end
        n_cmp++; if (bar_l !== 6'd9 || bar_r !== 6'd4) begin n_bad++;
            $display("FAIL same_edge: got bar_l %0d bar_r %0d expected 9 4", bar_l, bar_r); end
        @(posedge pixel_clock); #1;
        l_valid = 1'b0; r_valid = 1'b0;
        commit_wait();
        n_cmp++; if (bar_l !== 6'd8 || bar_r !== 6'd4) begin n_bad++;
            $display("FAIL next_frame: got bar_l %0d bar_r %0d expected 8 4", bar_l, bar_r); end
    endtask

    task automatic test_clamp();
        do_reset();
        send(0, 6'd63); send(1, 6'd40);
        commit_wait();
        n_cmp++; if (bar_l !== 6'd40 || peak_l !== 6'd40) begin n_bad++;
            $display("FAIL clamp_l: got bar %0d peak %0d expected 40 40", bar_l, peak_l); end
        n_cmp++; if (bar_r !== 6'd40) begin n_bad++;
            $display("FAIL clamp_r_fullscale: got %0d expected 40", bar_r); end
    endtask

    task automatic test_decay_hold();
        logic [5:0] eb, ep;
        do_reset();
        send(0, 6'd20);
        for (int k = 1; k <= 40; k++) begin
            commit_wait();
            eb = (k == 1) ? 6'd20 : ((k < 21) ? 6'(21 - k) : 6'd0);
            ep = (k <= 31) ? 6'd20 : 6'(51 - k);
            n_cmp++; if (bar_l !== eb) begin n_bad++;
                $display("FAIL decay_bar c%0d: got %0d expected %0d", k, bar_l, eb); end
            n_cmp++; if (peak_l !== ep) begin n_bad++;
                $display("FAIL decay_peak c%0d: got %0d expected %0d", k, peak_l, ep); end
        end
    endtask

    task automatic test_vblank_in_commit();
        int fc0;
        do_reset();
        send(0, 6'd10);
        fc0 = n_fc;
        vblank_pulse();
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        vblank_start = 1'b1;
        @(posedge pixel_clock); #1;
        vblank_start = 1'b0;
        repeat (8) @(negedge pixel_clock);
        n_cmp++; if (n_fc - fc0 !== 1) begin n_bad++;
            $display("FAIL vblank_ignored_count: got %0d expected 1", n_fc - fc0); end
        n_cmp++; if (busy !== 1'b0 || bar_l !== 6'd10) begin n_bad++;
            $display("FAIL vblank_ignored_state: got busy %b bar_l %0d expected 0 10", busy, bar_l); end
    endtask

    task automatic test_reset_mid_commit();
        int fc0;
        do_reset();
        send(0, 6'd10);
        fc0 = n_fc;
        vblank_pulse();
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        n_cmp++; if (bar_l !== 6'd10) begin n_bad++; $display("FAIL midreset_pre: got %0d expected 10", bar_l); end
        reset = 1'b1;
        @(posedge pixel_clock); #1;
        reset = 1'b0;
        repeat (6) @(negedge pixel_clock);
        n_cmp++; if (bar_l !== 6'd0 || peak_l !== 6'd0 || bar_r !== 6'd0) begin n_bad++;
            $display("FAIL midreset_levels: got bar_l %0d peak_l %0d bar_r %0d expected 0 0 0", bar_l, peak_l, bar_r); end
        n_cmp++; if (n_fc != fc0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL midreset_commit: got pulses %0d busy %b expected 0 0", n_fc - fc0, busy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_clamp();
        test_decay_hold();
        test_vblank_in_commit();
        test_reset_mid_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
